inst_queue: RTL and testbench

Instruction queue between the fetch stage and decode. Captures each fetched {pc, npc, inst} triple into a DEPTH-entry first-word-fall-through FIFO and presents the oldest entry to decode. Raises `stop` toward fetch when full so fetch holds its PC. Empties on `flush` when a jump or branch redirects fetch.

---
 rtl/inst_queue.sv | 79 +++++++
 tb/tb_inst_queue.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry first-word-fall-through FIFO of {pc, npc, inst}; a push is visible at the head one edge later.
// Backpressure: stop is asserted combinationally while full, and fetch holds its triple until stop drops; flush empties the queue on the next edge.
module inst_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_npc,
  input  logic [31:0]      in_inst,
  input  logic             flush,
  input  logic             id_ready,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_npc,
  output logic [31:0]      out_inst,
  output logic             stop,
  output logic [PTR_W:0]   count
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] inst;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wp;
  logic [PTR_W-1:0] rp;
  logic [PTR_W:0]   cnt;
  logic             push;
  logic             pop;

  assign out_valid = (cnt != '0);
  assign stop      = (cnt == (PTR_W+1)'(DEPTH));
  assign count     = cnt;

  // Full blocks a push even when a pop happens in the same cycle.
  assign push = in_valid & ~stop & ~flush;
  assign pop  = out_valid & id_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + PTR_W'(1);
      if (pop)  rp <= rp + PTR_W'(1);
      if (push && !pop)      cnt <= cnt + (PTR_W+1)'(1);
      else if (pop && !push) cnt <= cnt - (PTR_W+1)'(1);
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= '{pc: in_pc, npc: in_npc, inst: in_inst};
    end
  end

  // Empty presents an all-zero word, which decode sees as a nop.
  always_comb begin
    head = '0;
    if (out_valid) head = mem[rp];
  end

  assign out_pc   = head.pc;
  assign out_npc  = head.npc;
  assign out_inst = head.inst;

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue with a scoreboard queue of expected entries checked by a free-running monitor.
module tb_inst_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] inst;
  } trip_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [31:0]      in_pc = '0;
  logic [31:0]      in_npc = '0;
  logic [31:0]      in_inst = '0;
  logic             flush = 1'b0;
  logic             id_ready = 1'b0;
  logic             out_valid;
  logic [31:0]      out_pc;
  logic [31:0]      out_npc;
  logic [31:0]      out_inst;
  logic             stop;
  logic [PTR_W:0]   count;

  int checks = 0;
  int errors = 0;

  trip_t sb[$];
  bit    model_push;
  bit    do_pop;
  bit    do_push;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_pc(in_pc), .in_npc(in_npc), .in_inst(in_inst),
    .flush(flush), .id_ready(id_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_npc(out_npc), .out_inst(out_inst),
    .stop(stop), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference queue: pushes the triple when the model says it is accepted.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb.delete();
      model_push = 1'b0;
    end else if (flush) begin
      sb.delete();
      model_push = 1'b0;
    end else begin
      do_pop  = (sb.size() != 0) && id_ready;
      do_push = in_valid && (sb.size() < DEPTH);
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back('{pc: in_pc, npc: in_npc, inst: in_inst});
      model_push = do_push;
    end
  end

  // Monitor: every falling edge, compare DUT outputs against the reference queue.
  always @(negedge clk) begin
    chk("mon_count", 32'(count), 32'(sb.size()));
    chk("mon_valid", 32'(out_valid), 32'(sb.size() != 0));
    chk("mon_stop", 32'(stop), 32'(sb.size() == DEPTH));
    if (sb.size() != 0) begin
      chk("mon_pc", out_pc, sb[0].pc);
      chk("mon_npc", out_npc, sb[0].npc);
      chk("mon_inst", out_inst, sb[0].inst);
    end else begin
      chk("mon_pc_empty", out_pc, 32'h0);
      chk("mon_npc_empty", out_npc, 32'h0);
      chk("mon_inst_empty", out_inst, 32'h0);
    end
  end

  task automatic set_in(input logic v, input logic [31:0] pc);
    in_valid = v;
    in_pc    = pc;
    in_npc   = pc + 32'd4;
    in_inst  = 32'h2400_0000 | {16'h0, pc[15:0]};
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] pc;

  initial begin
    // Reset held with in_valid asserted.
    set_in(1'b1, 32'h0000_1000);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_stop", 32'(stop), 32'h0);
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_inst", out_inst, 32'h0);
      cyc();
    end
    rst_n = 1'b1;
    cyc();
    chk("first_push_valid", 32'(out_valid), 32'h1);
    chk("first_push_pc", out_pc, 32'h0000_1000);
    set_in(1'b0, 32'h0);
    id_ready = 1'b1;
    cyc();
    chk("first_pop_empty", 32'(count), 32'h0);

    // Fill to full with decode stalled.
    id_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 32'h0040_0000 + 32'(4 * i));
      cyc();
    end
    chk("fill_count", 32'(count), 32'h4);
    chk("fill_stop", 32'(stop), 32'h1);
    set_in(1'b1, 32'h0040_0010);
    cyc();
    cyc();
    chk("full_hold_count", 32'(count), 32'h4);
    chk("full_hold_pc", out_pc, 32'h0040_0000);

    // Drain with continuous fetch across the pointer wrap.
    id_ready = 1'b1;
    pc = 32'h0040_0010;
    for (int k = 0; k < 10; k++) begin
      chk("drain_pc", out_pc, 32'h0040_0000 + 32'(4 * k));
      cyc();
      if (model_push) pc = pc + 32'd4;
      set_in(1'b1, pc);
    end
    chk("drain_count", 32'(count), 32'h3);

    // Drop to two entries, then sustained push+pop.
    set_in(1'b0, pc);
    cyc();
    chk("pp_start_count", 32'(count), 32'h2);
    for (int k = 0; k < 5; k++) begin
      set_in(1'b1, pc);
      cyc();
      pc = pc + 32'd4;
      chk("pp_count", 32'(count), 32'h2);
      chk("pp_head", out_pc, pc - 32'd8);
    end

    // Back to three entries, then flush with push and pop requested.
    id_ready = 1'b0;
    set_in(1'b1, pc);
    cyc();
    chk("pre_flush_count", 32'(count), 32'h3);
    flush = 1'b1;
    id_ready = 1'b1;
    set_in(1'b1, 32'h0040_0FF0);
    cyc();
    chk("flush_count", 32'(count), 32'h0);
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_stop", 32'(stop), 32'h0);
    flush = 1'b0;
    id_ready = 1'b0;
    set_in(1'b1, 32'h0040_0100);
    cyc();
    set_in(1'b0, 32'h0);
    chk("post_flush_pc", out_pc, 32'h0040_0100);
    chk("post_flush_npc", out_npc, 32'h0040_0104);
    chk("post_flush_valid", 32'(out_valid), 32'h1);

    // Pop to empty, then keep id_ready high while empty.
    id_ready = 1'b1;
    for (int k = 0; k < 4; k++) cyc();
    chk("empty_count", 32'(count), 32'h0);
    chk("empty_inst", out_inst, 32'h0);

    // Two entries, then an asynchronous reset pulse between edges.
    id_ready = 1'b0;
    set_in(1'b1, 32'h0040_0200);
    cyc();
    set_in(1'b1, 32'h0040_0204);
    cyc();
    set_in(1'b0, 32'h0);
    chk("pre_rst_count", 32'(count), 32'h2);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'h0);
    chk("arst_valid", 32'(out_valid), 32'h0);
    chk("arst_pc", out_pc, 32'h0);
    chk("arst_inst", out_inst, 32'h0);
    rst_n = 1'b1;
    cyc();
    chk("after_rst_count", 32'(count), 32'h0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
